// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronizes and filters the device clock, deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and decodes E0/F0 prefixes.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_event
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0] sync_in;
  logic [1:0] sync_out;
  logic       clk_s;
  logic       dat_s;

  assign sync_in = {ps2_dat, ps2_clk};

  // Both bus lines idle high, so the chains reset to 1 to avoid a false edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic [1:0] chain_reg;
      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) chain_reg <= 2'b11;
        else       chain_reg <= {chain_reg[0], sync_in[gi]};
      end
      assign sync_out[gi] = chain_reg[1];
    end
  endgenerate

  assign clk_s = sync_out[0];
  assign dat_s = sync_out[1];

  logic          filt_reg;
  logic          filt_prev_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall_edge;

  // The filtered level flips only on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      filt_reg      <= 1'b1;
      filt_prev_reg <= 1'b1;
      filt_cnt_reg  <= '0;
    end else begin
      filt_prev_reg <= filt_reg;
      if (clk_s != filt_reg) begin
        if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
          filt_reg     <= clk_s;
          filt_cnt_reg <= '0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  assign fall_edge = filt_prev_reg & ~filt_reg;

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          par_reg, par_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [7:0]    byte_data_reg, byte_data_next;
  logic          byte_valid_reg, byte_valid_next;
  logic          parity_err_reg, parity_err_next;
  logic          frame_err_reg, frame_err_next;
  logic          ext_reg, ext_next;
  logic          brk_reg, brk_next;
  logic [7:0]    key_code_reg, key_code_next;
  logic          key_ext_reg, key_ext_next;
  logic          key_rel_reg, key_rel_next;
  logic          key_event_reg, key_event_next;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_reg        <= 1'b0;
      to_cnt_reg     <= '0;
      byte_data_reg  <= '0;
      byte_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      ext_reg        <= 1'b0;
      brk_reg        <= 1'b0;
      key_code_reg   <= '0;
      key_ext_reg    <= 1'b0;
      key_rel_reg    <= 1'b0;
      key_event_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      par_reg        <= par_next;
      to_cnt_reg     <= to_cnt_next;
      byte_data_reg  <= byte_data_next;
      byte_valid_reg <= byte_valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
      ext_reg        <= ext_next;
      brk_reg        <= brk_next;
      key_code_reg   <= key_code_next;
      key_ext_reg    <= key_ext_next;
      key_rel_reg    <= key_rel_next;
      key_event_reg  <= key_event_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    par_next        = par_reg;
    to_cnt_next     = '0;
    byte_data_next  = byte_data_reg;
    byte_valid_next = 1'b0;
    parity_err_next = 1'b0;
    frame_err_next  = 1'b0;

    if (state_reg != S_IDLE && !fall_edge) to_cnt_next = to_cnt_reg + 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (fall_edge && !dat_s) begin
          state_next   = S_DATA;
          bit_cnt_next = '0;
          shift_next   = '0;
          par_next     = 1'b0;
        end
      end
      S_DATA: begin
        if (fall_edge) begin
          shift_next   = {dat_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall_edge) begin
          par_next   = dat_s;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (fall_edge) begin
          state_next = S_IDLE;
          if (!dat_s) begin
            frame_err_next = 1'b1;
          end else if (^{shift_reg, par_reg}) begin
            byte_valid_next = 1'b1;
            byte_data_next  = shift_reg;
          end else begin
            parity_err_next = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A stalled device abandons the partial frame; landing in IDLE makes this fire once.
    if (state_reg != S_IDLE && !fall_edge && to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
      state_next     = S_IDLE;
      bit_cnt_next   = '0;
      shift_next     = '0;
      par_next       = 1'b0;
      to_cnt_next    = '0;
      frame_err_next = 1'b1;
    end
  end

  always_comb begin
    ext_next       = ext_reg;
    brk_next       = brk_reg;
    key_code_next  = key_code_reg;
    key_ext_next   = key_ext_reg;
    key_rel_next   = key_rel_reg;
    key_event_next = 1'b0;

    if (byte_valid_reg) begin
      if (byte_data_reg == 8'hE0) begin
        ext_next = 1'b1;
      end else if (byte_data_reg == 8'hF0) begin
        brk_next = 1'b1;
      end else begin
        key_code_next  = byte_data_reg;
        key_ext_next   = ext_reg;
        key_rel_next   = brk_reg;
        key_event_next = 1'b1;
        ext_next       = 1'b0;
        brk_next       = 1'b0;
      end
    end else if (parity_err_reg || frame_err_reg) begin
      ext_next = 1'b0;
      brk_next = 1'b0;
    end
  end

  assign byte_data    = byte_data_reg;
  assign byte_valid   = byte_valid_reg;
  assign parity_err   = parity_err_reg;
  assign frame_err    = frame_err_reg;
  assign key_code     = key_code_reg;
  assign key_extended = key_ext_reg;
  assign key_released = key_rel_reg;
  assign key_event    = key_event_reg;

endmodule
